// File: rtl/mcu_pkg.sv
// Shared MCU constants: default widths, the NOP encoding, opcode field masks
// and the fetch-stage redirect request type.
package mcu_pkg;

  localparam int unsigned ADDR_W_DEF      = 11;
  localparam int unsigned INSN_W_DEF      = 14;
  localparam int unsigned STACK_DEPTH_DEF = 8;

  localparam logic [13:0] NOP = 14'h0000;

  // Opcode field masks used by the decoder
  localparam logic [13:0] OPC_CLASS_MASK  = 14'h3000;
  localparam logic [13:0] OPC_JUMP_MASK   = 14'h3800;
  localparam logic [13:0] OPC_CALL        = 14'h2000;
  localparam logic [13:0] OPC_GOTO        = 14'h2800;
  localparam logic [13:0] OPC_RETLW_MASK  = 14'h3C00;
  localparam logic [13:0] OPC_RETLW       = 14'h3400;
  localparam logic [13:0] OPC_RETURN      = 14'h0008;
  localparam logic [13:0] OPC_JUMP_TARGET = 14'h07FF;

  // Redirect requests in descending priority order
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_RETURN,
    REQ_CALL,
    REQ_BRANCH,
    REQ_SKIP
  } req_e;

  function automatic logic is_jump(input logic [13:0] insn);
    return ((insn & OPC_JUMP_MASK) == OPC_CALL) ||
           ((insn & OPC_JUMP_MASK) == OPC_GOTO);
  endfunction

endpackage

// File: rtl/fetch_return_stack.sv
// Circular hardware return stack with occupancy count and sticky
// overflow/underflow flags. Push and pop are never asserted together.
module fetch_return_stack #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_dec;
  logic [PTR_W:0]    count;

  assign sp_dec = sp - 1'b1;
  assign top    = mem[sp_dec];

  // Stack storage: unreset, written at the current pointer on push
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

  // Pointer wraps freely; count saturates so overflow/underflow can be flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      sp <= sp + 1'b1;
      if (count == FULL) ovf <= 1'b1;
      else               count <= count + 1'b1;
    end else if (pop) begin
      sp <= sp_dec;
      if (count == '0) unf <= 1'b1;
      else             count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pic_fetch_unit.sv
// Instruction fetch stage: program counter, instruction register and
// redirect handling (GOTO/CALL/RETURN/skip) with one-cycle flush bubbles.
module pic_fetch_unit
  import mcu_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned INSN_W      = INSN_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [INSN_W-1:0] rom_data_in,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              call_en,
  input  logic              return_en,
  input  logic              skip_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [INSN_W-1:0] ir_out,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              stack_ovf,
  output logic              stack_unf
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic              push;
  logic              pop;
  req_e              req;

  assign rom_addr_out = pc;
  assign pc_inc       = pc + 1'b1;

  // Resolve simultaneous requests: return > call > branch > skip
  always_comb begin
    req = REQ_NONE;
    if      (return_en) req = REQ_RETURN;
    else if (call_en)   req = REQ_CALL;
    else if (branch_en) req = REQ_BRANCH;
    else if (skip_en)   req = REQ_SKIP;
  end

  // Next PC; skip and plain fetch both advance by one
  always_comb begin
    pc_next = pc_inc;
    unique case (req)
      REQ_RETURN:          pc_next = stack_top;
      REQ_CALL, REQ_BRANCH: pc_next = branch_addr;
      default:             pc_next = pc_inc;
    endcase
  end

  // PC already points at CALL address + 1, so it is the return address
  assign push = !stall && (req == REQ_CALL);
  assign pop  = !stall && (req == REQ_RETURN);

  // PC / IR pipeline; any request replaces the fetched word with a NOP bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      ir_out   <= INSN_W'(NOP);
      ir_valid <= 1'b0;
      ir_pc    <= '0;
    end else if (!stall) begin
      pc    <= pc_next;
      ir_pc <= pc;
      if (req == REQ_NONE) begin
        ir_out   <= rom_data_in;
        ir_valid <= 1'b1;
      end else begin
        ir_out   <= INSN_W'(NOP);
        ir_valid <= 1'b0;
      end
    end
  end

  fetch_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .top       (stack_top),
    .ovf       (stack_ovf),
    .unf       (stack_unf)
  );

endmodule

// File: tb/tb_pic_fetch_unit.sv
// Directed bench for pic_fetch_unit with a combinational ROM model.
module tb_pic_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic        stall;
  logic        branch_en;
  logic        call_en;
  logic        return_en;
  logic        skip_en;
  logic [10:0] branch_addr;
  logic [13:0] ir_out;
  logic        ir_valid;
  logic [10:0] ir_pc;
  logic        stack_ovf;
  logic        stack_unf;

  int tests_run = 0;
  int fails     = 0;

  function automatic logic [13:0] rom_word(input logic [10:0] a);
    case (a)
      11'h000: return 14'h01A5;
      11'h001: return 14'h01A4;
      default: return 14'h2000 | {3'b000, a};
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  pic_fetch_unit #(
    .ADDR_W      (11),
    .INSN_W      (14),
    .STACK_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_addr_out (rom_addr),
    .rom_data_in  (rom_data),
    .stall        (stall),
    .branch_en    (branch_en),
    .call_en      (call_en),
    .return_en    (return_en),
    .skip_en      (skip_en),
    .branch_addr  (branch_addr),
    .ir_out       (ir_out),
    .ir_valid     (ir_valid),
    .ir_pc        (ir_pc),
    .stack_ovf    (stack_ovf),
    .stack_unf    (stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; branch_en = 0; call_en = 0; return_en = 0; skip_en = 0;
    branch_addr = '0;
    #12;
    tests_run++; if (ir_out !== 14'h0000) begin fails++; $display("FAIL reset_ir got=%h exp=0000", ir_out); end
    tests_run++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", ir_valid); end
    tests_run++; if (ir_pc !== 11'h000) begin fails++; $display("FAIL reset_irpc got=%h exp=000", ir_pc); end
    tests_run++; if (rom_addr !== 11'h000) begin fails++; $display("FAIL reset_pc got=%h exp=000", rom_addr); end
    tests_run++; if ({stack_ovf, stack_unf} !== 2'b00) begin fails++; $display("FAIL reset_flags got=%b exp=00", {stack_ovf, stack_unf}); end
    rst_n = 1'b1;
    tick();
    tests_run++; if (ir_out !== 14'h01A5) begin fails++; $display("FAIL edge1_ir got=%h exp=01A5", ir_out); end
    tests_run++; if (ir_pc !== 11'h000 || ir_valid !== 1'b1) begin fails++; $display("FAIL edge1_irpc got=%h/%b exp=000/1", ir_pc, ir_valid); end
    tests_run++; if (rom_addr !== 11'h001) begin fails++; $display("FAIL edge1_pc got=%h exp=001", rom_addr); end
    tick();
    tests_run++; if (ir_out !== 14'h01A4 || ir_pc !== 11'h001) begin fails++; $display("FAIL edge2_ir got=%h@%h exp=01A4@001", ir_out, ir_pc); end
  endtask

  task automatic test_goto();
    branch_en = 1; branch_addr = 11'h019;
    tick();
    branch_en = 0;
    tests_run++; if (ir_valid !== 1'b0 || rom_addr !== 11'h019) begin fails++; $display("FAIL goto_first got=%b/%h exp=0/019", ir_valid, rom_addr); end
    tick();
    tests_run++; if (ir_valid !== 1'b1 || ir_pc !== 11'h019) begin fails++; $display("FAIL goto_land got=%b/%h exp=1/019", ir_valid, ir_pc); end
    for (int i = 0; i < 3; i++) begin
      branch_en = 1;
      tick();
      branch_en = 0;
      tests_run++; if (ir_valid !== 1'b0 || rom_addr !== 11'h019) begin fails++; $display("FAIL goto_loop_bubble[%0d] got=%b/%h exp=0/019", i, ir_valid, rom_addr); end
      tick();
      tests_run++; if (ir_valid !== 1'b1 || ir_pc !== 11'h019 || ir_out !== 14'h2019) begin fails++; $display("FAIL goto_loop_ir[%0d] got=%b/%h/%h exp=1/019/2019", i, ir_valid, ir_pc, ir_out); end
    end
  endtask

  task automatic test_call_return();
    branch_en = 1; branch_addr = 11'h00B;
    tick();
    branch_en = 0;
    tick();
    tests_run++; if (ir_pc !== 11'h00B || ir_valid !== 1'b1) begin fails++; $display("FAIL call_setup got=%h/%b exp=00B/1", ir_pc, ir_valid); end
    call_en = 1; branch_addr = 11'h01A;
    tick();
    call_en = 0;
    tests_run++; if (ir_valid !== 1'b0 || rom_addr !== 11'h01A) begin fails++; $display("FAIL call_bubble got=%b/%h exp=0/01A", ir_valid, rom_addr); end
    tick();
    tests_run++; if (ir_pc !== 11'h01A || ir_out !== 14'h201A) begin fails++; $display("FAIL call_target got=%h/%h exp=01A/201A", ir_pc, ir_out); end
    tick();
    return_en = 1;
    tick();
    return_en = 0;
    tests_run++; if (ir_valid !== 1'b0 || rom_addr !== 11'h00C) begin fails++; $display("FAIL ret_bubble got=%b/%h exp=0/00C", ir_valid, rom_addr); end
    tick();
    tests_run++; if (ir_pc !== 11'h00C || ir_valid !== 1'b1 || ir_out !== 14'h200C) begin fails++; $display("FAIL ret_land got=%h/%b/%h exp=00C/1/200C", ir_pc, ir_valid, ir_out); end
    tests_run++; if ({stack_ovf, stack_unf} !== 2'b00) begin fails++; $display("FAIL ret_flags got=%b exp=00", {stack_ovf, stack_unf}); end
  endtask

  task automatic test_skip();
    branch_en = 1; branch_addr = 11'h014;
    tick();
    branch_en = 0;
    tick();
    skip_en = 1;
    tick();
    skip_en = 0;
    tests_run++; if (ir_valid !== 1'b0 || ir_pc !== 11'h015 || rom_addr !== 11'h016) begin fails++; $display("FAIL skip_flush got=%b/%h/%h exp=0/015/016", ir_valid, ir_pc, rom_addr); end
    tick();
    tests_run++; if (ir_valid !== 1'b1 || ir_pc !== 11'h016) begin fails++; $display("FAIL skip_next got=%b/%h exp=1/016", ir_valid, ir_pc); end
  endtask

  task automatic test_stack_limits();
    logic [10:0] tgt;
    logic [10:0] exp_pc;
    for (int i = 0; i < 9; i++) begin
      tgt = 11'(32'h100 + i * 32'h20);
      call_en = 1; branch_addr = tgt;
      tick();
      call_en = 0;
      tests_run++; if (rom_addr !== tgt || stack_ovf !== (i == 8)) begin fails++; $display("FAIL call_nest[%0d] got=%h/%b exp=%h/%b", i, rom_addr, stack_ovf, tgt, (i == 8)); end
      tick();
    end
    for (int j = 0; j < 9; j++) begin
      exp_pc = (j < 8) ? 11'(32'h100 + (7 - j) * 32'h20 + 1) : 11'h1E1;
      return_en = 1;
      tick();
      return_en = 0;
      tests_run++; if (rom_addr !== exp_pc || stack_unf !== (j == 8)) begin fails++; $display("FAIL ret_nest[%0d] got=%h/%b exp=%h/%b", j, rom_addr, stack_unf, exp_pc, (j == 8)); end
      tick();
    end
  endtask

  task automatic test_priority();
    call_en = 1; branch_addr = 11'h300;
    tick();
    call_en = 0;
    tick();
    call_en = 1; return_en = 1; branch_addr = 11'h3F0;
    tick();
    call_en = 0; return_en = 0;
    tests_run++; if (rom_addr !== 11'h1E2 || ir_valid !== 1'b0) begin fails++; $display("FAIL prio_ret_call got=%h/%b exp=1E2/0", rom_addr, ir_valid); end
    tick();
    branch_en = 1; skip_en = 1; branch_addr = 11'h2AA;
    tick();
    branch_en = 0; skip_en = 0;
    tests_run++; if (rom_addr !== 11'h2AA) begin fails++; $display("FAIL prio_branch_skip got=%h exp=2AA", rom_addr); end
    tick();
  endtask

  task automatic test_stall();
    branch_en = 1; branch_addr = 11'h040;
    tick();
    branch_en = 0;
    tick();
    stall = 1; branch_en = 1; branch_addr = 11'h055;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (rom_addr !== 11'h041 || ir_pc !== 11'h040 || ir_out !== 14'h2040 || ir_valid !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d] got=%h/%h/%h/%b exp=041/040/2040/1", k, rom_addr, ir_pc, ir_out, ir_valid); end
    end
    stall = 0;
    tick();
    branch_en = 0;
    tests_run++; if (rom_addr !== 11'h055 || ir_valid !== 1'b0 || ir_pc !== 11'h041) begin fails++; $display("FAIL stall_release got=%h/%b/%h exp=055/0/041", rom_addr, ir_valid, ir_pc); end
    tick();
    tests_run++; if (ir_pc !== 11'h055 || ir_out !== 14'h2055) begin fails++; $display("FAIL stall_land got=%h/%h exp=055/2055", ir_pc, ir_out); end
  endtask

  task automatic test_wrap();
    branch_en = 1; branch_addr = 11'h7FF;
    tick();
    branch_en = 0;
    tick();
    tests_run++; if (ir_pc !== 11'h7FF || ir_out !== 14'h27FF || rom_addr !== 11'h000) begin fails++; $display("FAIL wrap_pc got=%h/%h/%h exp=7FF/27FF/000", ir_pc, ir_out, rom_addr); end
    tick();
    tests_run++; if (ir_pc !== 11'h000 || ir_out !== 14'h01A5) begin fails++; $display("FAIL wrap_next got=%h/%h exp=000/01A5", ir_pc, ir_out); end
  endtask

  task automatic test_reset_mid();
    tick();
    rst_n = 1'b0;
    #2;
    tests_run++; if (rom_addr !== 11'h000 || ir_valid !== 1'b0 || ir_out !== 14'h0000 || ir_pc !== 11'h000) begin fails++; $display("FAIL midreset_regs got=%h/%b/%h/%h exp=000/0/0000/000", rom_addr, ir_valid, ir_out, ir_pc); end
    tests_run++; if ({stack_ovf, stack_unf} !== 2'b00) begin fails++; $display("FAIL midreset_flags got=%b exp=00", {stack_ovf, stack_unf}); end
    #1;
    rst_n = 1'b1;
    tick();
    tests_run++; if (ir_out !== 14'h01A5 || ir_pc !== 11'h000 || ir_valid !== 1'b1 || rom_addr !== 11'h001) begin fails++; $display("FAIL midreset_restart got=%h/%h/%b/%h exp=01A5/000/1/001", ir_out, ir_pc, ir_valid, rom_addr); end
  endtask

  initial begin
    test_reset();
    test_goto();
    test_call_return();
    test_skip();
    test_stack_limits();
    test_priority();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/pic_fetch_unit.md
Name: pic_fetch_unit

Overview:
- Instruction-fetch stage for the 14-bit-instruction MCU core; drives the program ROM address and registers the returned word for the execute stage.
- Holds the 11-bit program counter, the instruction register (IR) and an 8-level hardware return stack.
- Implements the two-stage fetch/execute overlap: fetch of PC+1 runs alongside execution of IR.
- Applies GOTO/CALL/RETURN redirects and skip requests from the execute stage by flushing the fetched word to NOP.

Parameters:
- ADDR_W, 11: program address width; PC wraps modulo 2^ADDR_W.
- INSN_W, 14: instruction width.
- STACK_DEPTH, 8: return-stack entries; power of two.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rom_addr_out  output  ADDR_W  address to program ROM; equals PC, combinational from the PC register.
- rom_data_in  input  INSN_W  word from program ROM, combinational read of rom_addr_out.
- stall  input  1  hold PC, IR, stack; all redirects ignored this cycle.
- branch_en  input  1  GOTO: load PC from branch_addr.
- call_en  input  1  CALL: push PC, then load PC from branch_addr.
- return_en  input  1  RETURN/RETLW: pop stack into PC.
- skip_en  input  1  conditional skip taken: discard the word fetched this cycle.
- branch_addr  input  ADDR_W  target for branch_en/call_en.
- ir_out  output  INSN_W  instruction register to execute stage.
- ir_valid  output  1  1 = ir_out is a real fetched instruction; 0 = injected NOP bubble.
- ir_pc  output  ADDR_W  ROM address ir_out was fetched from.
- stack_ovf  output  1  sticky: a push occurred with STACK_DEPTH entries in use.
- stack_unf  output  1  sticky: a pop occurred with zero entries in use.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - PC=0, ir_out=14'h0000 (NOP), ir_valid=0, ir_pc=0.
  - Stack pointer=0, entry count=0, stack_ovf=0, stack_unf=0.
  - Stack RAM contents are don't-care.
  - Reset asserted mid-operation takes effect immediately; pending requests are lost.
- Normal cycle (stall=0, no request):
  - IR<=rom_data_in, ir_pc<=PC, ir_valid<=1, PC<=PC+1.
  - 0x7FF+1 wraps to 0x000.
- Latency: a word at address A appears on ir_out one clock after PC=A.
  - The first valid IR is the word at address 0, one edge after reset release.
- Request priority, when more than one is asserted: return_en > call_en > branch_en > skip_en.
  - Multiple simultaneous requests are illegal but deterministic.
- Applying any request:
  - IR<=NOP, ir_valid<=0, ir_pc<=PC.
  - The word fetched this cycle is flushed, giving a 1-cycle bubble.
- Per-request PC update:
  - branch_en: PC<=branch_addr.
  - call_en: stack[sp]<=PC (PC already equals CALL address+1), sp<=sp+1 mod DEPTH, count<=min(count+1,DEPTH), PC<=branch_addr.
  - return_en: sp<=sp-1 mod DEPTH, PC<=stack[sp-1], count<=max(count-1,0).
  - skip_en: PC<=PC+1.
- Overflow: push with count=DEPTH overwrites the oldest entry (circular) and sets stack_ovf.
- Underflow: pop with count=0 still decrements sp and uses stack[sp-1], and sets stack_unf.
- stack_ovf and stack_unf clear only on reset.
- stall=1: every register holds; rom_addr_out stays constant.
  - The execute stage keeps any request asserted until stall drops.
- Execute-stage contract: a request arrives in the same cycle its instruction sits in IR.

Decomposition:
- Shared package mcu_pkg holds:
  - ADDR_W, INSN_W, STACK_DEPTH defaults.
  - NOP constant 14'h0000.
  - Opcode field masks used by the decoder.
- Sub-module fetch_return_stack holds:
  - The STACK_DEPTH x ADDR_W register array, sp and count.
  - push/pop inputs, top output, ovf/unf sticky flags.
- pic_fetch_unit keeps the PC, IR, request priority and flush logic.

Test Plan:
- Reset and straight-line fetch:
  - ROM address 0 holds 14'h01A5 and address 1 holds 14'h01A4; release rst_n.
  - Required: edge 1 gives ir_out=01A5, ir_pc=0, ir_valid=1, rom_addr_out=1; edge 2 gives ir_out=01A4.
- GOTO self-loop: branch_en with branch_addr=0x019 while ir_pc=0x019.
  - Required: next cycle ir_valid=0 and PC=0x019; the following cycle IR holds the word at 0x019.
  - Repeating this, ir_valid must alternate 1/0 indefinitely.
- CALL/RETURN round trip: call_en at ir_pc=0x00B with target 0x01A, then return_en later.
  - Required: after RETURN, PC=0x00C; one bubble after each redirect.
  - Stack count returns to 0 with stack_ovf=stack_unf=0.
- Skip: skip_en at ir_pc=0x014.
  - Required: the word from 0x015 is flushed (ir_valid=0); next valid IR comes from ir_pc=0x016.
- Stack limits and priority:
  - 9 nested CALLs: stack_ovf=1 on the 9th; 9 RETURNs afterwards set stack_unf.
  - call_en with return_en in the same cycle: only the pop happens.
- Stall and reset mid-stream:
  - stall=1 for 3 cycles with branch_en held: PC and IR stay frozen and the branch applies on the first unstalled edge.
  - rst_n pulsed low between clock edges forces PC=0, ir_valid=0 immediately.
